// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store, alternating on contention.
// Latency: access starts the cycle after an idle-cycle request, lasts MEM_LATENCY cycles, Done follows.
// Backpressure: Stall_IF / Stall_MEM stay high from request until the stage's Done pulse.
module unified_mem_arbiter #(
    parameter int MEM_LATENCY = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              IF_Req,
    input  logic [ADDR_W-1:0] IF_Addr,
    input  logic              Flush,
    output logic [DATA_W-1:0] IF_Instr,
    output logic              IF_Done,
    output logic              Stall_IF,
    input  logic              MEM_Read,
    input  logic              MEM_Write,
    input  logic [ADDR_W-1:0] MEM_Addr,
    input  logic [DATA_W-1:0] MEM_WData,
    output logic [DATA_W-1:0] MEM_RData,
    output logic              MEM_Done,
    output logic              Stall_MEM,
    output logic              Mem_En,
    output logic              Mem_We,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic [DATA_W-1:0] Mem_WData,
    input  logic [DATA_W-1:0] Mem_RData
);
    localparam int               CNT_W    = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, I_ACC, D_ACC} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              last, last_nxt;     // 1: data stage was granted most recently
    logic              kill, kill_nxt;     // in-flight fetch has been flushed
    logic [DATA_W-1:0] if_instr_nxt, mem_rdata_nxt, mem_wdata_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic              if_done_nxt, mem_done_nxt, mem_en_nxt, mem_we_nxt;
    logic              if_elig, mem_elig, grant_d;

    // Stalls are purely combinational so the pipeline freezes in the same cycle it asks
    assign Stall_IF  = IF_Req & ~IF_Done;
    assign Stall_MEM = (MEM_Read | MEM_Write) & ~MEM_Done;

    // Next-state, arbitration and output-register updates
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        last_nxt      = last;
        kill_nxt      = kill;
        if_instr_nxt  = IF_Instr;
        mem_rdata_nxt = MEM_RData;
        if_done_nxt   = 1'b0;
        mem_done_nxt  = 1'b0;
        mem_en_nxt    = Mem_En;
        mem_we_nxt    = Mem_We;
        mem_addr_nxt  = Mem_Addr;
        mem_wdata_nxt = Mem_WData;

        // A stage whose Done is showing this cycle is finishing, not requesting again
        if_elig  = IF_Req & ~IF_Done & ~Flush;
        mem_elig = (MEM_Read | MEM_Write) & ~MEM_Done;
        // On a tie the data stage wins unless it was the last one served
        grant_d  = mem_elig & (~if_elig | ~last);

        case (state)
            IDLE: begin
                if (if_elig | mem_elig) begin
                    cnt_nxt    = '0;
                    mem_en_nxt = 1'b1;
                    last_nxt   = grant_d;
                    if (grant_d) begin
                        state_nxt     = D_ACC;
                        mem_we_nxt    = MEM_Write;
                        mem_addr_nxt  = MEM_Addr;
                        mem_wdata_nxt = MEM_WData;
                    end else begin
                        state_nxt    = I_ACC;
                        mem_we_nxt   = 1'b0;
                        mem_addr_nxt = IF_Addr;
                    end
                end
            end
            I_ACC: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (Flush) begin
                    kill_nxt = 1'b1;
                end
                if (cnt == CNT_LAST) begin
                    state_nxt  = IDLE;
                    mem_en_nxt = 1'b0;
                    kill_nxt   = 1'b0;
                    // A flush seen in any access cycle, including this one, drops the result
                    if (~kill & ~Flush) begin
                        if_done_nxt  = 1'b1;
                        if_instr_nxt = Mem_RData;
                    end
                end
            end
            D_ACC: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt == CNT_LAST) begin
                    state_nxt    = IDLE;
                    mem_en_nxt   = 1'b0;
                    mem_we_nxt   = 1'b0;
                    mem_done_nxt = 1'b1;
                    if (~Mem_We) begin
                        mem_rdata_nxt = Mem_RData;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any access without a Done pulse
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            last      <= 1'b0;
            kill      <= 1'b0;
            IF_Instr  <= '0;
            MEM_RData <= '0;
            IF_Done   <= 1'b0;
            MEM_Done  <= 1'b0;
            Mem_En    <= 1'b0;
            Mem_We    <= 1'b0;
            Mem_Addr  <= '0;
            Mem_WData <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            last      <= last_nxt;
            kill      <= kill_nxt;
            IF_Instr  <= if_instr_nxt;
            MEM_RData <= mem_rdata_nxt;
            IF_Done   <= if_done_nxt;
            MEM_Done  <= mem_done_nxt;
            Mem_En    <= mem_en_nxt;
            Mem_We    <= mem_we_nxt;
            Mem_Addr  <= mem_addr_nxt;
            Mem_WData <= mem_wdata_nxt;
        end
    end

endmodule
